// File: rtl/text_ram_ctrl_if.sv
// text_ram_ctrl_if: CPU access, video fetch and command/status signals of the text buffer
interface text_ram_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_wdata;
  logic [DATA_W/8-1:0] a_be;
  logic                a_write;
  logic                a_ready;
  logic [DATA_W-1:0]   a_rdata;
  logic [ADDR_W-1:0]   v_addr;
  logic [DATA_W-1:0]   v_rdata;
  logic                cmd_valid;
  logic [1:0]          cmd_op;
  logic [DATA_W-1:0]   cmd_fill;
  logic                cmd_ready;
  logic                busy;
  logic [ADDR_W-1:0]   origin_row;
  modport master (
    output a_addr, a_wdata, a_be, a_write, v_addr, cmd_valid, cmd_op, cmd_fill,
    input  a_ready, a_rdata, v_rdata, cmd_ready, busy, origin_row
  );
  modport slave (
    input  a_addr, a_wdata, a_be, a_write, v_addr, cmd_valid, cmd_op, cmd_fill,
    output a_ready, a_rdata, v_rdata, cmd_ready, busy, origin_row
  );
endinterface

// File: rtl/text_ram_ctrl.sv
// text_ram_ctrl: ring-addressed text-mode cell buffer with CPU/video ports and clear/scroll/home engine
module text_ram_ctrl #(
  parameter int    COLS                 = 80,
  parameter int    ROWS                 = 30,
  parameter int    DATA_W               = 16,
  parameter int    ADDR_W               = 12,
  parameter string INIT_FRAME_ENABLE    = "DISABLE",
  parameter string INIT_FRAME_FILE_NAME = ""
) (
  input logic            clock,
  input logic            reset,
  text_ram_ctrl_if.slave bus
);
  localparam int DEPTH = COLS * ROWS;
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'(DEPTH - COLS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  typedef enum logic [2:0] {IDLE, CLEAR, SCROLL, HOME, NOP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, base, base_n, origin, origin_n, eng_addr;
  logic [DATA_W-1:0] fill, fill_n;
  logic              eng_we, busy, we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [NB-1:0]     wbe;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] a_raddr, v_raddr;
  logic              a_rv, v_rv;
  logic [DATA_W-1:0] a_rdata, v_rdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] l);
    return {1'b0, l} < DEPTH_X;
  endfunction

  function automatic logic [ADDR_W-1:0] xlat(input logic [ADDR_W-1:0] l, input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, l} + {1'b0, b};
    return s >= DEPTH_X ? ADDR_W'(s - DEPTH_X) : s[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    base_n   = base;
    origin_n = origin;
    fill_n   = fill;
    eng_we   = 1'b0;
    eng_addr = cnt;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        fill_n  = bus.cmd_fill;
        cnt_n   = '0;
        state_n = bus.cmd_op == 2'b00 ? CLEAR : bus.cmd_op == 2'b01 ? SCROLL : bus.cmd_op == 2'b10 ? HOME : NOP;
      end
      CLEAR: begin
        eng_we = 1'b1;
        cnt_n  = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_n  = IDLE;
          base_n   = '0;
          origin_n = '0;
        end
      end
      SCROLL: begin
        eng_we   = 1'b1;
        eng_addr = base + cnt;
        cnt_n    = cnt + ADDR_W'(1);
        if (cnt == LAST_COL) begin
          state_n  = IDLE;
          base_n   = base == TOP_BASE ? '0 : base + COLS_A;
          origin_n = origin == LAST_ROW ? '0 : origin + ADDR_W'(1);
        end
      end
      HOME: begin
        state_n  = IDLE;
        base_n   = '0;
        origin_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      base   <= '0;
      origin <= '0;
      fill   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      base   <= base_n;
      origin <= origin_n;
      fill   <= fill_n;
    end

  assign busy = state != IDLE;
  assign we   = eng_we | (bus.a_write & ~busy & in_range(bus.a_addr));
  assign wa   = eng_we ? eng_addr : xlat(bus.a_addr, base);
  assign wd   = eng_we ? fill : bus.a_wdata;
  assign wbe  = eng_we ? '1 : bus.a_be;

  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) ram[wa][i*8 +: 8] <= wd[i*8 +: 8];

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a_rv    <= 1'b0;
      v_rv    <= 1'b0;
      a_raddr <= '0;
      v_raddr <= '0;
      a_rdata <= '0;
      v_rdata <= '0;
    end else begin
      a_rv    <= in_range(bus.a_addr);
      v_rv    <= in_range(bus.v_addr);
      a_raddr <= in_range(bus.a_addr) ? xlat(bus.a_addr, base) : '0;
      v_raddr <= in_range(bus.v_addr) ? xlat(bus.v_addr, base) : '0;
      a_rdata <= a_rv ? ram[a_raddr] : '0;
      v_rdata <= v_rv ? ram[v_raddr] : '0;
    end

  assign bus.busy       = busy;
  assign bus.a_ready    = ~busy;
  assign bus.cmd_ready  = ~busy;
  assign bus.origin_row = origin;
  assign bus.a_rdata    = a_rdata;
  assign bus.v_rdata    = v_rdata;
endmodule

// File: tb/tb_text_ram_ctrl.sv
// tb_text_ram_ctrl: random and directed stimulus scored against a logical-screen reference model
module tb_text_ram_ctrl;
  localparam int COLS = 80, ROWS = 30, DW = 16, AW = 12, DEPTH = COLS * ROWS;
  typedef struct { bit port; int la; logic [DW-1:0] val; logic [DW-1:0] mask; } exp_t;

  logic clock = 1'b0, reset = 1'b1;
  text_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  text_ram_ctrl #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DW), .ADDR_W(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] kn [DEPTH];
  int org = 0, wp, ap_la, vp_la, ap_ph, vp_ph;
  bit m_busy = 0, a_chk = 0, v_chk = 0, ap_chk = 0, vp_chk = 0;
  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int phys_of(int l);
    return l >= DEPTH ? -1 : (l + org * COLS) % DEPTH;
  endfunction

  function automatic void expect_rd(bit port, int la, int ph);
    exp_t x;
    x.port = port;
    x.la = la;
    x.val = ph < 0 ? '0 : mem[ph];
    x.mask = ph < 0 ? '1 : kn[ph];
    if (x.mask != 0) q.push_back(x);
  endfunction

  task automatic chk(string nm, int la, logic [DW-1:0] got, logic [DW-1:0] exp, logic [DW-1:0] mask);
    vectors++;
    if ((got & mask) !== (exp & mask)) begin
      miscompares++;
      $display("FAIL %s L=%0d: got %h expected %h (mask %h)", nm, la, got, exp, mask);
    end
  endtask

  task automatic chk_i(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // reference model: screen memory updated per cycle, reads snapshot one edge after the address
  initial forever begin
    @(posedge clock);
    if (reset) begin
      ap_chk = 0;
      vp_chk = 0;
    end else begin
      if (ap_chk) expect_rd(0, ap_la, ap_ph);
      if (vp_chk) expect_rd(1, vp_la, vp_ph);
      if (bus.a_write && !m_busy) begin
        wp = phys_of(int'(bus.a_addr));
        if (wp >= 0)
          for (int i = 0; i < 2; i++)
            if (bus.a_be[i]) begin
              mem[wp][i*8 +: 8] = bus.a_wdata[i*8 +: 8];
              kn[wp][i*8 +: 8] = 8'hFF;
            end
      end
      ap_chk = a_chk;
      ap_la = int'(bus.a_addr);
      ap_ph = phys_of(ap_la);
      vp_chk = v_chk;
      vp_la = int'(bus.v_addr);
      vp_ph = phys_of(vp_la);
    end
  end

  initial forever begin
    @(negedge clock);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.port ? "v_rdata" : "a_rdata", e.la, e.port ? bus.v_rdata : bus.a_rdata, e.val, e.mask);
    end
  end

  task automatic step(int aa, logic [DW-1:0] wd, logic [1:0] be, bit wr, int va, bit ac, bit vc);
    bus.a_addr = AW'(aa);
    bus.a_wdata = wd;
    bus.a_be = be;
    bus.a_write = wr;
    bus.v_addr = AW'(va);
    a_chk = ac;
    v_chk = vc;
    @(negedge clock);
  endtask

  task automatic rnd_steps(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, DEPTH + 40), DW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, DEPTH + 40), 1, 1);
  endtask

  task automatic readback(int n);
    for (int l = 0; l < n; l++) step(l, '0, 2'b00, 0, $urandom_range(0, DEPTH - 1), 1, 1);
  endtask

  task automatic cmd(logic [1:0] op, logic [DW-1:0] fill, int exp_cyc, int drop_la, int sim_la, logic [DW-1:0] sim_wd);
    int n = 0;
    chk_i("cmd_ready_idle", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_fill = fill;
    a_chk = 0;
    v_chk = 0;
    bus.a_write = sim_la >= 0;
    bus.a_addr = AW'(sim_la);
    bus.a_wdata = sim_wd;
    bus.a_be = 2'b11;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    bus.cmd_fill = ~fill;
    m_busy = 1;
    while (bus.busy && n < exp_cyc + 8) begin
      chk_i("a_ready_busy", int'(bus.a_ready), 0);
      chk_i("cmd_ready_busy", int'(bus.cmd_ready), 0);
      bus.a_write = n == 2 && drop_la >= 0;
      bus.a_addr = AW'(drop_la);
      bus.a_wdata = 16'hDEAD;
      n++;
      @(negedge clock);
    end
    bus.a_write = 1'b0;
    chk_i("busy_cycles", n, exp_cyc);
    if (op == 2'b00) begin
      for (int p = 0; p < DEPTH; p++) begin
        mem[p] = fill;
        kn[p] = '1;
      end
      org = 0;
    end else if (op == 2'b01) begin
      for (int c = 0; c < COLS; c++) begin
        mem[org * COLS + c] = fill;
        kn[org * COLS + c] = '1;
      end
      org = (org + 1) % ROWS;
    end else if (op == 2'b10) org = 0;
    m_busy = 0;
    chk_i("origin_row", int'(bus.origin_row), org);
    chk_i("a_ready_done", int'(bus.a_ready), 1);
  endtask

  initial begin
    for (int p = 0; p < DEPTH; p++) kn[p] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_fill = '0;
    bus.a_write = 1'b0;
    bus.a_addr = '0;
    bus.a_wdata = '0;
    bus.a_be = '0;
    bus.v_addr = '0;
    repeat (3) @(negedge clock);
    chk_i("reset_busy", int'(bus.busy), 0);
    chk_i("reset_a_ready", int'(bus.a_ready), 1);
    chk_i("reset_cmd_ready", int'(bus.cmd_ready), 1);
    chk_i("reset_origin", int'(bus.origin_row), 0);
    chk("reset_a_rdata", 0, bus.a_rdata, '0, '1);
    chk("reset_v_rdata", 0, bus.v_rdata, '0, '1);
    reset = 1'b0;
    step(6, 16'h0000, 2'b11, 1, 0, 0, 0);
    step(5, 16'h1F41, 2'b11, 1, 0, 0, 0);
    step(0, '0, 2'b00, 0, 6, 0, 1);
    step(0, '0, 2'b00, 0, 6, 0, 1);
    step(0, '0, 2'b00, 0, 5, 0, 1);
    step(0, '0, 2'b00, 0, 6, 0, 1);
    step(0, '0, 2'b00, 0, 6, 0, 1);
    step(7, 16'hAAAA, 2'b11, 1, 0, 0, 0);
    step(7, 16'h0055, 2'b01, 1, 0, 0, 0);
    step(7, '0, 2'b00, 0, 7, 1, 1);
    step(DEPTH, 16'h1234, 2'b11, 1, 0, 0, 0);
    step(DEPTH, '0, 2'b00, 0, DEPTH, 1, 1);
    step(7, '0, 2'b00, 0, 5, 1, 1);
    step(0, '0, 2'b00, 0, 0, 0, 0);
    rnd_steps(400);
    cmd(2'b00, 16'h0720, DEPTH, 10, -1, '0);
    readback(DEPTH);
    step(DEPTH + 5, '0, 2'b00, 0, DEPTH, 1, 1);
    cmd(2'b11, 16'hFFFF, 1, -1, -1, '0);
    for (int l = 0; l < DEPTH; l++) step(l, DW'(l / COLS), 2'b11, 1, 0, 0, 0);
    cmd(2'b01, 16'h0020, COLS, 100, COLS * 5 + 3, 16'hBEEF);
    readback(DEPTH);
    rnd_steps(300);
    cmd(2'b10, 16'h0000, 1, -1, -1, '0);
    rnd_steps(50);
    for (int s = 0; s < ROWS; s++) begin
      cmd(2'b01, DW'(16'h0100 + s), COLS, -1, -1, '0);
      step(0, '0, 2'b00, 0, DEPTH - 1, 1, 1);
      step((DEPTH - 1), '0, 2'b00, 0, 0, 1, 1);
      step($urandom_range(0, DEPTH - 1), '0, 2'b00, 0, $urandom_range(0, DEPTH - 1), 1, 1);
    end
    chk_i("origin_wrap", int'(bus.origin_row), 0);
    for (int l = 0; l < COLS; l++) step(l, DW'(16'h1000 + l), 2'b11, 1, 0, 0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'b01;
    bus.cmd_fill = 16'h5A5A;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    m_busy = 1;
    for (int k = 1; k < 40; k++) begin
      chk_i("busy_mid_scroll", int'(bus.busy), 1);
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_origin", int'(bus.origin_row), 0);
    chk_i("rst_a_ready", int'(bus.a_ready), 1);
    chk_i("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_a_rdata", 0, bus.a_rdata, '0, '1);
    chk("rst_v_rdata", 0, bus.v_rdata, '0, '1);
    for (int c = 0; c < 39; c++) mem[c] = 16'h5A5A;
    org = 0;
    m_busy = 0;
    @(negedge clock);
    reset = 1'b0;
    cmd(2'b10, 16'h0000, 1, -1, -1, '0);
    readback(COLS);
    rnd_steps(200);
    repeat (3) step(0, '0, 2'b00, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
